// File: rtl/s2_conv_sequencer_pkg.sv
// Shared types and defaults for the stride-2 conv layer sequencer.
// Holds the FSM state enum and the output-buffer address helper.
package s2_pkg;
  localparam int N_FILTERS_DEF  = 4;
  localparam int POS_BITS_DEF   = 2;
  localparam int OUT_STRIDE_DEF = 36;
  localparam int AW_DEF         = 8;
  localparam int FLT_W          = 2;

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, FINISH} state_e;

  // Full-width address so the caller can detect overflow before truncating.
  function automatic logic [31:0] out_addr(input logic [31:0] flt,
                                           input logic [31:0] pos,
                                           input logic [31:0] stride);
    return flt * stride + pos;
  endfunction
endpackage

// File: rtl/s2_conv_sequencer_if.sv
// Handshake bundle between the sequencer, the filter loader and the output buffer.
// master = sequencer side, slave = environment/datapath side.
interface s2_conv_sequencer_if import s2_pkg::*; #(
  parameter int POS_BITS = POS_BITS_DEF,
  parameter int AW       = AW_DEF
) ();
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  flt_req;
  logic [FLT_W-1:0]      flt_sel;
  logic                  flt_ack;
  logic [FLT_W-1:0]      proc_dir;
  logic [2*POS_BITS-1:0] proc_counter;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic                  wr_ready;

  modport master (
    input  start, flt_ack, wr_ready,
    output busy, done, flt_req, flt_sel, proc_dir, proc_counter, wr_en, wr_addr
  );

  modport slave (
    output start, flt_ack, wr_ready,
    input  busy, done, flt_req, flt_sel, proc_dir, proc_counter, wr_en, wr_addr
  );
endinterface

// File: rtl/s2_conv_sequencer_pos_counter.sv
// {row,col} window position counter; col occupies the low bits so a plain
// increment advances col first and carries into row.
module pos_counter #(
  parameter int POS_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc,
  input  logic                  clr,
  output logic [2*POS_BITS-1:0] pos,
  output logic                  last
);
  localparam int PW = 2 * POS_BITS;

  logic [PW-1:0] pos_q, pos_d;

  always_comb begin
    pos_d = pos_q;
    if (clr)      pos_d = '0;
    else if (inc) pos_d = pos_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pos_q <= '0;
    else        pos_q <= pos_d;
  end

  assign pos  = pos_q;
  assign last = &pos_q;
endmodule

// File: rtl/s2_conv_sequencer.sv
// Sweeps every filter over every {row,col} window position, loading each
// filter bank first and strobing one output-buffer write per position.
module s2_conv_sequencer import s2_pkg::*; #(
  parameter int N_FILTERS  = N_FILTERS_DEF,
  parameter int POS_BITS   = POS_BITS_DEF,
  parameter int OUT_STRIDE = OUT_STRIDE_DEF,
  parameter int AW         = AW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  s2_conv_sequencer_if.master  bus
);
  localparam int PW = 2 * POS_BITS;

  state_e           state_q;
  logic [FLT_W-1:0] flt_q;
  logic             busy_q, done_q, flt_req_q, wr_en_q;

  logic [PW-1:0]    pos;
  logic             last, hs, clr;
  logic [31:0]      addr_w;

  // A write only retires when the buffer accepts it; otherwise everything holds.
  assign hs  = (state_q == RUN) && wr_en_q && bus.wr_ready;
  assign clr = ((state_q == IDLE) && bus.start) || (hs && last);

  pos_counter #(.POS_BITS(POS_BITS)) u_pos (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (hs),
    .clr  (clr),
    .pos  (pos),
    .last (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      flt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      flt_req_q <= 1'b0;
      wr_en_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          flt_q     <= '0;
          flt_req_q <= 1'b1;
          busy_q    <= 1'b1;
          state_q   <= LOAD;
        end
        LOAD: if (bus.flt_ack) begin
          flt_req_q <= 1'b0;
          state_q   <= SETTLE;
        end
        SETTLE: begin
          wr_en_q <= 1'b1;
          state_q <= RUN;
        end
        RUN: if (hs && last) begin
          wr_en_q <= 1'b0;
          if (flt_q == FLT_W'(N_FILTERS - 1)) begin
            done_q  <= 1'b1;
            state_q <= FINISH;
          end else begin
            flt_q     <= flt_q + FLT_W'(1);
            flt_req_q <= 1'b1;
            state_q   <= LOAD;
          end
        end
        FINISH: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign addr_w = out_addr(32'(flt_q), 32'(pos), 32'(OUT_STRIDE));

  always_ff @(posedge clk) begin
    if (rst_n && wr_en_q) assert (addr_w < 32'(1 << AW));
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.flt_req      = flt_req_q;
  assign bus.flt_sel      = flt_q;
  assign bus.proc_dir     = flt_q;
  assign bus.proc_counter = pos;
  assign bus.wr_en        = wr_en_q;
  assign bus.wr_addr      = addr_w[AW-1:0];
endmodule

// File: tb/tb_s2_conv_sequencer.sv
// Directed + randomized bench for s2_conv_sequencer against a queue model of
// the expected write-address stream.
module tb_s2_conv_sequencer;
  localparam int NF = 4, PB = 2, STRIDE = 36, AW = 8, NPOS = 16, NWR = NF * NPOS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  s2_conv_sequencer_if #(.POS_BITS(PB), .AW(AW)) bus ();

  s2_conv_sequencer #(.N_FILTERS(NF), .POS_BITS(PB), .OUT_STRIDE(STRIDE), .AW(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0, n_bad = 0;
  int exp_q[$];
  int got_q[$];
  int ack_delay = 1, req_cnt = 0, rdy_pct = 100;
  int stall_addr = -1, stall_left = 0, extra_start_addr = -1;
  int hs_cnt = 0, done_cnt = 0, pass_cycles = 0;
  int cyc_ref = 0;
  int first_got[$];
  bit stalling = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},    bus.busy, 0);
    chk({tag, "_done"},    bus.done, 0);
    chk({tag, "_flt_req"}, bus.flt_req, 0);
    chk({tag, "_wr_en"},   bus.wr_en, 0);
    chk({tag, "_dir"},     bus.proc_dir, 0);
    chk({tag, "_sel"},     bus.flt_sel, 0);
    chk({tag, "_pc"},      bus.proc_counter, 0);
    chk({tag, "_addr"},    bus.wr_addr, 0);
  endtask

  task automatic drive(input bit st);
    @(posedge clk); #1;
    bus.start   = st;
    bus.flt_ack = (req_cnt >= ack_delay);
    stalling    = 0;
    if (exp_q.size() > 0 && exp_q[0] == stall_addr && stall_left > 0) begin
      stalling = 1;
      stall_left--;
    end
    bus.wr_ready = stalling ? 1'b0 : ($urandom_range(99) < rdy_pct);
    if (extra_start_addr >= 0 && exp_q.size() > 0 && exp_q[0] == extra_start_addr) begin
      bus.start = 1'b1;
      extra_start_addr = -1;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    pass_cycles++;
    if (!bus.flt_req && req_cnt > 0) chk("load_len", req_cnt, ack_delay + 1);
    if (bus.flt_req) begin
      req_cnt++;
      chk("load_no_wr", bus.wr_en, 0);
      chk("load_busy", bus.busy, 1);
      if (exp_q.size() > 0) chk("load_sel", bus.flt_sel, exp_q[0] / STRIDE);
    end else req_cnt = 0;
    chk("dir_eq_sel", bus.proc_dir, bus.flt_sel);
    if (bus.wr_en) begin
      chk("wr_busy", bus.busy, 1);
      if (exp_q.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        chk("wr_addr", bus.wr_addr, exp_q[0]);
        chk("wr_pc", bus.proc_counter, exp_q[0] % STRIDE);
        chk("wr_dir", bus.proc_dir, exp_q[0] / STRIDE);
      end
      if (stalling) begin
        chk("stall_addr", bus.wr_addr, 43);
        chk("stall_pc", bus.proc_counter, 7);
      end
      if (bus.wr_ready) begin
        got_q.push_back(int'(bus.wr_addr));
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        hs_cnt++;
      end
    end
    if (bus.done) begin
      done_cnt++;
      chk("done_all_written", exp_q.size(), 0);
      chk("done_busy", bus.busy, 1);
    end
  endtask

  task automatic tick(input bit st = 0);
    drive(st);
    sample();
  endtask

  task automatic start_pass();
    exp_q.delete();
    got_q.delete();
    hs_cnt = 0;
    pass_cycles = 0;
    for (int f = 0; f < NF; f++)
      for (int p = 0; p < NPOS; p++) exp_q.push_back(f * STRIDE + p);
    tick(1);
    chk("start_idle_busy", bus.busy, 0);
    chk("start_done_low", bus.done, 0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, done_cnt - d0, 1);
    chk({tag, "_writes"}, hs_cnt, NWR);
  endtask

  task automatic idle_check(input string tag);
    tick();
    chk({tag, "_done_single"}, bus.done, 0);
    chk({tag, "_idle_busy"}, bus.busy, 0);
  endtask

  initial begin
    int n;
    int d_before;
    bus.start = 0; bus.flt_ack = 0; bus.wr_ready = 0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    tick(); tick();
    chk("idle_busy", bus.busy, 0);

    // Full pass immediately followed by a back-to-back pass.
    start_pass();
    wait_done("full", 500);
    cyc_ref = pass_cycles;
    first_got = got_q;
    chk("full_addr15", got_q[15], 15);
    chk("full_addr16", got_q[16], 36);
    chk("full_addr32", got_q[32], 72);
    chk("full_addr63", got_q[63], 123);
    start_pass();
    wait_done("b2b", 500);
    chk("b2b_cycles", pass_cycles, cyc_ref);
    chk("b2b_same_stream", got_q == first_got, 1);
    idle_check("b2b");

    // Buffer stall at filter 1, position 7.
    stall_addr = 43; stall_left = 5;
    start_pass();
    wait_done("stall", 500);
    chk("stall_applied", stall_left, 0);
    chk("stall_cycles", pass_cycles, cyc_ref + 5);
    stall_addr = -1;
    idle_check("stall");

    // Slow filter load.
    ack_delay = 10;
    start_pass();
    wait_done("slow", 800);
    chk("slow_cycles", pass_cycles, cyc_ref + NF * 9);
    ack_delay = 1;
    idle_check("slow");

    // Start while busy during filter 2.
    extra_start_addr = 2 * STRIDE + 3;
    start_pass();
    wait_done("rebusy", 500);
    chk("rebusy_cycles", pass_cycles, cyc_ref);
    idle_check("rebusy");
    tick(); tick();
    chk("rebusy_no_restart", bus.busy, 0);

    // Reset mid-pass at filter 3, position 5.
    start_pass();
    n = 0;
    while (exp_q.size() > 0 && exp_q[0] != 3 * STRIDE + 5 && n < 500) begin
      tick();
      n++;
    end
    drive(0);
    chk("prerst_addr", bus.wr_addr, 3 * STRIDE + 5);
    d_before = done_cnt;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    exp_q.delete();
    req_cnt = 0;
    sample();
    tick(); tick();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) tick();
    chk("midrst_no_done", done_cnt, d_before);
    chk("midrst_idle", bus.busy, 0);
    start_pass();
    wait_done("postrst", 500);
    chk("postrst_cycles", pass_cycles, cyc_ref);
    chk("postrst_same_stream", got_q == first_got, 1);
    idle_check("postrst");

    // Randomized ack latency and buffer backpressure.
    rdy_pct = 60;
    for (int r = 0; r < 3; r++) begin
      ack_delay = $urandom_range(1, 4);
      start_pass();
      wait_done("rand", 1500);
      chk("rand_same_stream", got_q == first_got, 1);
      idle_check("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
